// File: rtl/noc_pkg.sv
// Shared NoC packet definitions: field positions within the 64-bit flit and the packet type.
package noc_pkg;

  localparam int VC_BIT   = 63;
  localparam int HDIR_BIT = 62;
  localparam int VDIR_BIT = 61;
  localparam int HHOP_MSB = 55;
  localparam int HHOP_LSB = 52;
  localparam int VHOP_MSB = 51;
  localparam int VHOP_LSB = 48;
  localparam int SRC_MSB  = 47;
  localparam int SRC_LSB  = 32;
  localparam int DST_MSB  = 31;
  localparam int DST_LSB  = 16;

  typedef logic [63:0] packet_t;

  // A packet has reached its destination once both hop counts are exhausted.
  function automatic logic hops_pending(input packet_t p);
    return p[HHOP_MSB:VHOP_LSB] != '0;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Per-VC circular buffer; pointers carry an extra wrap bit so full and empty are unambiguous.
module vc_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is data only; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pe_eject_nic.sv
// Router-to-PE ejection port: per-VC buffering, destination checks and round-robin delivery.
module pe_eject_nic
  import noc_pkg::*;
#(
  parameter int PACKET_SIZE = 64,
  parameter int DEPTH       = 2,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   polarity,
  input  logic                   si,
  input  logic [PACKET_SIZE-1:0] di,
  output logic                   ri,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PACKET_SIZE-1:0] out_data,
  output logic                   out_vc,
  output logic [CNT_W-1:0]       rx_cnt_vc0,
  output logic [CNT_W-1:0]       rx_cnt_vc1,
  output logic                   vc_err,
  output logic                   hop_err,
  input  logic                   clr_err
);

  logic                   full0, full1, empty0, empty1;
  logic [PACKET_SIZE-1:0] head0, head1;
  logic                   acc, push0, push1, pop0, pop1, pop_any;
  logic                   sel, sel_c, last, locked;

  // Only the VC matching the current polarity is advertised to the router.
  assign ri    = reset && !(polarity ? full1 : full0);
  assign acc   = si && ri;
  assign push0 = acc && !polarity;
  assign push1 = acc && polarity;

  vc_fifo #(.DEPTH(DEPTH), .WIDTH(PACKET_SIZE)) u_fifo_vc0 (
    .clk   (clk),
    .reset (reset),
    .push  (push0),
    .pop   (pop0),
    .din   (di),
    .full  (full0),
    .empty (empty0),
    .head  (head0)
  );

  vc_fifo #(.DEPTH(DEPTH), .WIDTH(PACKET_SIZE)) u_fifo_vc1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .pop   (pop1),
    .din   (di),
    .full  (full1),
    .empty (empty1),
    .head  (head1)
  );

  assign out_valid = !(empty0 && empty1);

  // A stalled head stays selected; otherwise pick the non-empty VC, alternating on contention.
  always_comb begin
    sel_c = sel;
    if (!locked) begin
      if (!empty0 && !empty1)
        sel_c = !last;
      else
        sel_c = empty0;
    end
  end

  assign out_vc   = out_valid && sel_c;
  assign out_data = out_valid ? (sel_c ? head1 : head0) : '0;
  assign pop_any  = out_valid && out_ready;
  assign pop0     = pop_any && !sel_c;
  assign pop1     = pop_any && sel_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel    <= 1'b0;
      last   <= 1'b1;
      locked <= 1'b0;
    end else begin
      sel    <= sel_c;
      locked <= out_valid && !out_ready;
      if (pop_any)
        last <= sel_c;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_cnt_vc0 <= '0;
      rx_cnt_vc1 <= '0;
    end else begin
      if (push0)
        rx_cnt_vc0 <= rx_cnt_vc0 + CNT_W'(1);
      if (push1)
        rx_cnt_vc1 <= rx_cnt_vc1 + CNT_W'(1);
    end
  end

  // A newly detected error takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vc_err  <= 1'b0;
      hop_err <= 1'b0;
    end else begin
      if (acc && (di[VC_BIT] != polarity))
        vc_err <= 1'b1;
      else if (clr_err)
        vc_err <= 1'b0;
      if (acc && hops_pending(di))
        hop_err <= 1'b1;
      else if (clr_err)
        hop_err <= 1'b0;
    end
  end

endmodule
